// File: rtl/sprite_color_mapper.sv
// Two-stage sprite compositor: fixed-priority sprites over a gradient.
// Define COLLISION_DETECT_EN to enable per-frame sprite-overlap reporting.
module sprite_color_mapper #(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 8,
    parameter int FLASH_SHIFT = 3
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_start,
    input  logic                      pixel_valid,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic [NUM_SPRITES*10-1:0] sprite_x,
    input  logic [NUM_SPRITES*10-1:0] sprite_y,
    input  logic [NUM_SPRITES-1:0]    sprite_en,
    input  logic [NUM_SPRITES-1:0]    sprite_flash,
    input  logic [NUM_SPRITES*24-1:0] sprite_rgb,
    output logic [7:0]                Red,
    output logic [7:0]                Green,
    output logic [7:0]                Blue,
    output logic                      out_valid,
    output logic [NUM_SPRITES-1:0]    collision_mask,
    output logic                      collision_valid
);

    logic [NUM_SPRITES-1:0] hit_d;
    logic        any_d, any_q;
    logic [23:0] rgb_d, rgb_q;
    logic        flash_d, flash_q;
    logic [6:0]  dx_d, dx_q;
    logic        pv_d, pv_q;
    logic [7:0]  red_d, red_q;
    logic [7:0]  green_d, green_q;
    logic [7:0]  blue_d, blue_q;
    logic        ov_d, ov_q;
    logic [7:0]  frame_cnt_d, frame_cnt_q;

    // Bounds are compared at 11 bits so sprites near x/y=1023 never wrap.
    always_comb begin
        hit_d   = '0;
        any_d   = 1'b0;
        rgb_d   = '0;
        flash_d = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit_d[i] = sprite_en[i]
                && ({1'b0, DrawX} >= {1'b0, sprite_x[10*i +: 10]})
                && ({1'b0, DrawX} <
                    ({1'b0, sprite_x[10*i +: 10]} + 11'(SPRITE_W)))
                && ({1'b0, DrawY} >= {1'b0, sprite_y[10*i +: 10]})
                && ({1'b0, DrawY} <
                    ({1'b0, sprite_y[10*i +: 10]} + 11'(SPRITE_H)));
        end
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_d[i]) begin
                any_d   = 1'b1;
                rgb_d   = sprite_rgb[24*i +: 24];
                flash_d = sprite_flash[i];
            end
        end
        dx_d = DrawX[9:3];
        pv_d = pixel_valid;
    end

    always_comb begin
        red_d       = '0;
        green_d     = '0;
        blue_d      = '0;
        ov_d        = pv_q;
        frame_cnt_d = frame_start ? frame_cnt_q + 8'd1 : frame_cnt_q;
        if (pv_q) begin
            if (any_q) begin
                {red_d, green_d, blue_d} =
                    rgb_q ^ {24{flash_q & frame_cnt_q[FLASH_SHIFT]}};
            end else begin
                blue_d = 8'h7f - {1'b0, dx_q};
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            any_q       <= 1'b0;
            rgb_q       <= '0;
            flash_q     <= 1'b0;
            dx_q        <= '0;
            pv_q        <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            ov_q        <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            any_q       <= any_d;
            rgb_q       <= rgb_d;
            flash_q     <= flash_d;
            dx_q        <= dx_d;
            pv_q        <= pv_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            ov_q        <= ov_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign Red       = red_q;
    assign Green     = green_q;
    assign Blue      = blue_q;
    assign out_valid = ov_q;

`ifdef COLLISION_DETECT_EN
    logic [NUM_SPRITES-1:0] acc_d, acc_q;
    logic [NUM_SPRITES-1:0] mask_d, mask_q;
    logic                   cv_d, cv_q;
    logic                   multi;

    // The pixel seen alongside frame_start still lands in the outgoing mask.
    always_comb begin
        multi  = pixel_valid
              && ((hit_d & (hit_d - NUM_SPRITES'(1))) != '0);
        acc_d  = acc_q | (multi ? hit_d : '0);
        mask_d = mask_q;
        cv_d   = frame_start;
        if (frame_start) begin
            mask_d = acc_d;
            acc_d  = '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc_q  <= '0;
            mask_q <= '0;
            cv_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            mask_q <= mask_d;
            cv_q   <= cv_d;
        end
    end

    assign collision_mask  = mask_q;
    assign collision_valid = cv_q;
`else
    assign collision_mask  = '0;
    assign collision_valid = 1'b0;
`endif

endmodule
